// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch (I) and data (D) requesters with
// round-robin grants, back-to-back chaining on completion and a wait-cycle watchdog.
module mem_port_arbiter #(
  parameter int N       = 64,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_req,
  input  logic [N-1:0] i_addr,
  output logic         i_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic         d_ack,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [N-1:0] mem_rdata,
  output logic [N-1:0] rdata,
  output logic         sel,
  output logic         err,
  output logic         busy
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last_d;
  logic          w_last_d_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_busy;
  logic          w_timeout;
  logic          w_done;

  // A transaction ends on mem_ready, or on the watchdog when ready never came.
  assign w_busy    = (r_state != IDLE);
  assign w_timeout = w_busy && !mem_ready && (r_cnt == CW'(TIMEOUT));
  assign w_done    = w_busy && (mem_ready || w_timeout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last_d <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_next;
      r_last_d <= w_last_d_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // On completion the other port is granted directly if it is waiting; the finishing
  // port's request is still high this cycle, so it must never be re-granted here.
  always_comb begin
    w_next       = r_state;
    w_last_d_nxt = r_last_d;
    w_cnt_nxt    = '0;
    case (r_state)
      IDLE: begin
        if (i_req && d_req) w_next = r_last_d ? BUSY_I : BUSY_D;
        else if (i_req)     w_next = BUSY_I;
        else if (d_req)     w_next = BUSY_D;
      end
      BUSY_I: begin
        if (w_done) begin
          w_last_d_nxt = 1'b0;
          w_next       = d_req ? BUSY_D : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      BUSY_D: begin
        if (w_done) begin
          w_last_d_nxt = 1'b1;
          w_next       = i_req ? BUSY_I : IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    busy      = 1'b0;
    sel       = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    case (r_state)
      BUSY_I: begin
        mem_req  = 1'b1;
        busy     = 1'b1;
        mem_addr = i_addr;
        i_ack    = w_done;
      end
      BUSY_D: begin
        mem_req   = 1'b1;
        busy      = 1'b1;
        sel       = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_ack     = w_done;
      end
      default: ;
    endcase
    err   = w_timeout;
    rdata = (w_busy && mem_ready) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a round-level model predicts grant order, ack
// cycles and payloads; a memory responder plays latencies; a monitor checks every ack.
module tb_mem_port_arbiter;
  localparam int N = 64;
  localparam int T = 15;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
  logic [N-1:0] i_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
  logic         i_ack, d_ack, mem_req, mem_we, sel, err, busy;
  logic [N-1:0] mem_addr, mem_wdata, rdata;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  bit model_last_d = 1'b1;

  typedef struct {
    bit           port_d;
    int           cyc;
    bit           err;
    bit           we;
    logic [N-1:0] rdata;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
  } exp_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] data;
  } rsp_t;

  typedef struct {
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] rd;
    bit           we;
    int           lat;
  } txn_t;

  exp_t sb_q[$];
  rsp_t rsp_q[$];

  mem_port_arbiter #(.N(N), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .rdata(rdata),
    .sel(sel), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  // Memory side: mem_ready only in the cycle the model scheduled, junk rdata otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) rsp_q.delete(0);
      if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
        mem_ready = 1'b1;
        mem_rdata = rsp_q[0].data;
        rsp_q.delete(0);
      end else begin
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom};
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack && d_ack) begin
        miscompares++;
        $display("FAIL both_acks cyc=%0d: i_ack=%b d_ack=%b, required at most one", cyc, i_ack, d_ack);
      end
      if (i_ack || d_ack) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_ack cyc=%0d: i_ack=%b d_ack=%b, required no ack", cyc, i_ack, d_ack);
        end else begin
          e = sb_q.pop_front();
          if (d_ack != e.port_d || i_ack == e.port_d || cyc != e.cyc || err != e.err ||
              rdata != e.rdata || mem_addr != e.addr || mem_wdata != e.wdata ||
              mem_we != e.we || sel != e.port_d || !mem_req || !busy) begin
            miscompares++;
            $display("FAIL ack: got cyc=%0d d_ack=%b err=%b rdata=%h addr=%h wdata=%h we=%b sel=%b req=%b busy=%b; required cyc=%0d d_ack=%b err=%b rdata=%h addr=%h wdata=%h we=%b sel=%b",
                     cyc, d_ack, err, rdata, mem_addr, mem_wdata, mem_we, sel, mem_req, busy,
                     e.cyc, e.port_d, e.err, e.rdata, e.addr, e.wdata, e.we, e.port_d);
          end
        end
      end else if (rdata != '0 || err) begin
        miscompares++;
        $display("FAIL no_ack_outputs cyc=%0d: rdata=%h err=%b, required 0 and 0", cyc, rdata, err);
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %b required %b", name, cyc, act, req);
    end
  endtask

  task automatic checkn(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %h required %h", name, cyc, act, req);
    end
  endtask

  function automatic txn_t mk(input logic [N-1:0] addr, input logic [N-1:0] wdata,
                              input bit we, input int lat, input logic [N-1:0] rd);
    txn_t t;
    t.addr = addr; t.wdata = wdata; t.we = we; t.lat = lat; t.rd = rd;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.addr  = {$urandom, $urandom};
    t.wdata = {$urandom, $urandom};
    t.rd    = {$urandom, $urandom};
    t.we    = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 9) == 0) t.lat = $urandom_range(T - 1, T + 2);
    else                           t.lat = $urandom_range(0, 4);
    return t;
  endfunction

  // Expected response of one granted transaction: ack after min(lat, T) wait cycles.
  task automatic expect_txn(input bit port_d, input txn_t t, input int g);
    exp_t e;
    rsp_t r;
    e.port_d = port_d;
    e.err    = (t.lat > T);
    e.cyc    = g + (e.err ? T : t.lat);
    e.rdata  = e.err ? '0 : t.rd;
    e.addr   = t.addr;
    e.we     = port_d ? t.we : 1'b0;
    e.wdata  = port_d ? t.wdata : '0;
    sb_q.push_back(e);
    if (!e.err) begin
      r.cyc  = g + t.lat;
      r.data = t.rd;
      rsp_q.push_back(r);
    end
  endtask

  task automatic raise_i(input txn_t t);
    i_addr = t.addr;
    i_req  = 1'b1;
  endtask

  task automatic raise_d(input txn_t t);
    d_addr  = t.addr;
    d_wdata = t.wdata;
    d_we    = t.we;
    d_req   = 1'b1;
  endtask

  // mode 0: I only, 1: D only, 2: both together, 3: I then D k cycles later, 4: D then I.
  task automatic run_round(input int mode, input txn_t ti, input txn_t td, input int k_in);
    bit   two, first_d;
    int   s, k, m1, m2, a1, a2, a_i, a_d, last;
    txn_t t1, t2;
    two = (mode >= 2);
    case (mode)
      0:       first_d = 1'b0;
      1:       first_d = 1'b1;
      2:       first_d = !model_last_d;
      3:       first_d = 1'b0;
      default: first_d = 1'b1;
    endcase
    t1 = first_d ? td : ti;
    t2 = first_d ? ti : td;
    m1 = (t1.lat > T) ? T : t1.lat;
    m2 = (t2.lat > T) ? T : t2.lat;
    k  = (k_in < 1) ? 1 : ((k_in > m1 + 1) ? m1 + 1 : k_in);
    @(posedge clk);
    #1;
    s  = cyc;
    a1 = s + 1 + m1;
    a2 = a1 + 1 + m2;
    expect_txn(first_d, t1, s + 1);
    if (two) expect_txn(!first_d, t2, a1 + 1);
    model_last_d = two ? !first_d : first_d;
    a_i  = -100;
    a_d  = -100;
    if (first_d) a_d = a1; else a_i = a1;
    if (two) begin
      if (first_d) a_i = a2; else a_d = a2;
    end
    last = two ? a2 : a1;
    if (mode == 0 || mode == 2 || mode == 3) raise_i(ti);
    if (mode == 1 || mode == 2 || mode == 4) raise_d(td);
    while (cyc < last + 1) begin
      @(posedge clk);
      #1;
      if (mode == 3 && cyc == s + k) raise_d(td);
      if (mode == 4 && cyc == s + k) raise_i(ti);
      if (cyc == a_i + 1) begin
        i_req  = 1'b0;
        i_addr = {$urandom, $urandom};
      end
      if (cyc == a_d + 1) begin
        d_req   = 1'b0;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
      end
    end
    @(negedge clk);
    check1("idle_busy", busy, 1'b0);
    check1("idle_mem_req", mem_req, 1'b0);
    check1("idle_sel", sel, 1'b0);
    checkn("idle_mem_addr", mem_addr, '0);
  endtask

  initial begin
    txn_t dummy;
    int   s;
    dummy = mk(64'h0, 64'h0, 1'b0, 0, 64'h0);
    d_we    = 1'b1;
    d_wdata = 64'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_mem_req", mem_req, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_sel", sel, 1'b0);
    check1("rst_mem_we", mem_we, 1'b0);
    check1("rst_acks", i_ack | d_ack | err, 1'b0);
    checkn("rst_mem_wdata", mem_wdata, '0);
    checkn("rst_rdata", rdata, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check1("post_rst_busy", busy, 1'b0);

    run_round(2, mk(64'h1000, 64'h0, 1'b0, 1, 64'hA1), mk(64'h2000, 64'h77, 1'b0, 2, 64'hB2), 0);
    run_round(2, mk(64'h1004, 64'h0, 1'b0, 0, 64'hA3), mk(64'h2008, 64'h99, 1'b1, 3, 64'hB4), 0);
    run_round(0, mk(64'h100, 64'h0, 1'b0, 2, 64'hDEAD), dummy, 0);
    run_round(1, dummy, mk(64'h40, 64'h55, 1'b1, 0, 64'h0), 0);
    run_round(1, dummy, mk(64'h80, 64'h0, 1'b0, T + 5, 64'hBEEF), 0);
    run_round(1, dummy, mk(64'h88, 64'h0, 1'b0, T, 64'hCAFE), 0);
    run_round(0, mk(64'h90, 64'h0, 1'b0, T - 1, 64'hF00D), dummy, 0);
    run_round(3, mk(64'h200, 64'h0, 1'b0, 3, 64'h11), mk(64'h300, 64'h22, 1'b1, 1, 64'h33), 4);
    run_round(4, mk(64'h400, 64'h0, 1'b0, 2, 64'h44), mk(64'h500, 64'h55, 1'b0, 4, 64'h66), 2);

    for (int r = 0; r < 250; r++) begin
      run_round($urandom_range(0, 4), rand_txn(), rand_txn(), $urandom_range(1, T + 1));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset in the middle of a data load: the transaction vanishes without an ack.
    @(posedge clk);
    #1;
    d_addr = 64'hABC0;
    d_we   = 1'b0;
    d_req  = 1'b1;
    s      = cyc;
    while (cyc < s + 3) begin
      @(posedge clk);
      #1;
    end
    check1("pre_rst_busy", busy, 1'b1);
    check1("pre_rst_sel", sel, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check1("mid_rst_mem_req", mem_req, 1'b0);
    check1("mid_rst_sel", sel, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;
    d_req = 1'b0;
    @(posedge clk);
    #1;
    reset        = 1'b0;
    model_last_d = 1'b1;
    run_round(0, mk(64'h600, 64'h0, 1'b0, 1, 64'h1234), dummy, 0);

    repeat (3) @(posedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_acks: got %0d outstanding, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
